// File: rtl/trojan_resp_logger_if.sv
// Reader-side handshake bundle for the response logger word FIFO.
interface trojan_resp_logger_if #(
  parameter int WORD_W = 8
);
  logic              rd_valid;
  logic              rd_ready;
  logic [WORD_W-1:0] rd_data;

  // Logger side drives the head word, the reader drives ready.
  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/trojan_resp_logger.sv
// Response logger: captures NUM_SAMPLES response bits, packs them LSB-first
// into WORD_W words for a valid/ready reader and folds the same bit stream
// into a 16-bit MISR signature for golden-value comparison.
module trojan_resp_logger #(
  parameter int WORD_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_SAMPLES = 16
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sample_in,
  trojan_resp_logger_if.master rd,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [15:0]          sig
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(WORD_W);
  localparam int SW = $clog2(NUM_SAMPLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       sig_q, sig_d;
  logic              ovf_q, ovf_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [WORD_W-1:0] word_cur, push_word;
  logic              push, start_ok, fb;

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic              valid, pop, full, wr_en, drop;

  // MISR feedback taps 15,13,12,10 with the incoming response bit.
  assign fb = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10] ^ sample_in;

  // Next-state, packing and signature update.
  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    pack_d    = pack_q;
    bcnt_d    = bcnt_q;
    scnt_d    = scnt_q;
    push      = 1'b0;
    push_word = pack_q;
    start_ok  = 1'b0;
    word_cur  = pack_q | (WORD_W'(sample_in) << bcnt_q);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = S_CAPTURE;
          sig_d    = '0;
          pack_d   = '0;
          bcnt_d   = '0;
          scnt_d   = '0;
        end
      end
      S_CAPTURE: begin
        sig_d  = {sig_q[14:0], fb};
        scnt_d = scnt_q + SW'(1);
        // Full word leaves on the same edge its last bit arrives.
        if (bcnt_q == BW'(WORD_W - 1)) begin
          push      = 1'b1;
          push_word = word_cur;
          pack_d    = '0;
          bcnt_d    = '0;
        end else begin
          pack_d = word_cur;
          bcnt_d = bcnt_q + BW'(1);
        end
        // A partial word left behind needs one extra FLUSH cycle.
        if (scnt_q == SW'(NUM_SAMPLES - 1))
          state_d = push ? S_DONE : S_FLUSH;
      end
      S_FLUSH: begin
        push      = 1'b1;
        push_word = pack_q;   // unused upper bits are already zero
        pack_d    = '0;
        bcnt_d    = '0;
        state_d   = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control: a pop frees the slot a same-cycle push needs when full.
  assign valid = (cnt_q != '0);
  assign pop   = valid && rd.rd_ready;
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // Sticky drop flag, cleared only when a new run is accepted.
  always_comb begin
    ovf_d = ovf_q | drop;
    if (start_ok) ovf_d = 1'b0;
  end

  // Control state registers.
  always_ff @(posedge CK) begin
    if (reset) begin
      state_q <= S_IDLE;
      sig_q   <= '0;
      ovf_q   <= 1'b0;
      pack_q  <= '0;
      bcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      ovf_q   <= ovf_d;
      pack_q  <= pack_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge CK) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + PW'(1);
      if (pop)   rd_q <= rd_q + PW'(1);
      if (wr_en && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!wr_en && pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  // FIFO storage; stale entries are never visible because the head is gated.
  always_ff @(posedge CK) begin
    if (wr_en) mem_q[wr_q] <= push_word;
  end

  assign rd.rd_valid = valid;
  assign rd.rd_data  = valid ? mem_q[rd_q] : '0;
  assign busy        = (state_q == S_CAPTURE) || (state_q == S_FLUSH);
  assign done        = (state_q == S_DONE);
  assign overflow    = ovf_q;
  assign sig         = sig_q;

endmodule

// File: tb/tb_trojan_resp_logger.sv
// Directed bench for trojan_resp_logger: a 16-sample instance and a
// 4-sample instance (exercises the FLUSH path) share clock and reset.
module tb_trojan_resp_logger;
  logic        CK, reset;
  logic        start, sample_in, busy, done, overflow;
  logic [15:0] sig;
  logic        start4, sample4, busy4, done4, overflow4;
  logic [15:0] sig4;
  int          n_chk, n_pass;

  trojan_resp_logger_if #(.WORD_W(8)) rif ();
  trojan_resp_logger_if #(.WORD_W(8)) rif4 ();

  trojan_resp_logger #(.WORD_W(8), .FIFO_DEPTH(4), .NUM_SAMPLES(16)) dut (
    .CK(CK), .reset(reset), .start(start), .sample_in(sample_in), .rd(rif),
    .busy(busy), .done(done), .overflow(overflow), .sig(sig));

  trojan_resp_logger #(.WORD_W(8), .FIFO_DEPTH(4), .NUM_SAMPLES(4)) dut4 (
    .CK(CK), .reset(reset), .start(start4), .sample_in(sample4), .rd(rif4),
    .busy(busy4), .done(done4), .overflow(overflow4), .sig(sig4));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step;
    @(posedge CK);
    #1;
  endtask

  task automatic run16(input logic [15:0] b);
    start = 1'b1; step; start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      sample_in = b[k]; step;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; step; step;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %0h exp 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %0h exp 0", done); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %0h exp 0", overflow); else n_pass++;
    n_chk++; if (sig !== 16'h0000) $display("FAIL reset_sig got %h exp 0000", sig); else n_pass++;
    n_chk++; if (rif.rd_valid !== 1'b0) $display("FAIL reset_rdv got %0h exp 0", rif.rd_valid); else n_pass++;
    n_chk++; if (rif.rd_data !== 8'h00) $display("FAIL reset_rdd got %h exp 00", rif.rd_data); else n_pass++;
    n_chk++; if (busy4 !== 1'b0 || done4 !== 1'b0 || sig4 !== 16'h0)
      $display("FAIL reset_dut4 got busy=%0h done=%0h sig=%h exp 0/0/0000", busy4, done4, sig4); else n_pass++;
    reset = 1'b0; step;
  endtask

  task automatic test_zero_run;
    rif.rd_ready = 1'b0;
    start = 1'b1; step; start = 1'b0;
    n_chk++; if (busy !== 1'b1) $display("FAIL zero_busy got %0h exp 1", busy); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      sample_in = 1'b0; step;
      if (k == 14) begin
        n_chk++; if (done !== 1'b0) $display("FAIL zero_done_early got %0h exp 0", done); else n_pass++;
      end
    end
    n_chk++; if (done !== 1'b1) $display("FAIL zero_done got %0h exp 1", done); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL zero_busy_end got %0h exp 0", busy); else n_pass++;
    n_chk++; if (sig !== 16'h0000) $display("FAIL zero_sig got %h exp 0000", sig); else n_pass++;
    n_chk++; if (rif.rd_valid !== 1'b1 || rif.rd_data !== 8'h00)
      $display("FAIL zero_word0 got v=%0h d=%h exp 1/00", rif.rd_valid, rif.rd_data); else n_pass++;
    rif.rd_ready = 1'b1; step;
    n_chk++; if (rif.rd_valid !== 1'b1 || rif.rd_data !== 8'h00)
      $display("FAIL zero_word1 got v=%0h d=%h exp 1/00", rif.rd_valid, rif.rd_data); else n_pass++;
    step;
    n_chk++; if (rif.rd_valid !== 1'b0) $display("FAIL zero_empty got %0h exp 0", rif.rd_valid); else n_pass++;
    rif.rd_ready = 1'b0;
  endtask

  // Reader always ready; a stray start mid-capture must be ignored.
  task automatic test_pattern;
    logic [15:0] bits;
    logic [7:0]  q[$];
    bits = 16'hFF0D;
    rif.rd_ready = 1'b1;
    start = 1'b1; step; start = 1'b0;
    for (int k = 0; k < 19; k++) begin
      start = (k == 3);
      sample_in = (k < 16) ? bits[k] : 1'b0;
      if (rif.rd_valid) q.push_back(rif.rd_data);
      step;
    end
    start = 1'b0;
    n_chk++; if (q.size() != 2) $display("FAIL pat_count got %0d exp 2", q.size()); else n_pass++;
    n_chk++; if (q.size() < 1 || q[0] !== 8'h0D) $display("FAIL pat_word0 got %h exp 0d", (q.size() > 0) ? q[0] : 8'hxx); else n_pass++;
    n_chk++; if (q.size() < 2 || q[1] !== 8'hFF) $display("FAIL pat_word1 got %h exp ff", (q.size() > 1) ? q[1] : 8'hxx); else n_pass++;
    n_chk++; if (rif.rd_valid !== 1'b0) $display("FAIL pat_empty got %0h exp 0", rif.rd_valid); else n_pass++;
    n_chk++; if (sig !== 16'hB0EE) $display("FAIL pat_sig got %h exp b0ee", sig); else n_pass++;
    n_chk++; if (done !== 1'b1) $display("FAIL pat_done got %0h exp 1", done); else n_pass++;
    rif.rd_ready = 1'b0;
  endtask

  task automatic test_flush;
    rif4.rd_ready = 1'b0;
    start4 = 1'b1; step; start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample4 = (k == 0); step;
    end
    sample4 = 1'b0;
    n_chk++; if (busy4 !== 1'b1 || done4 !== 1'b0 || rif4.rd_valid !== 1'b0)
      $display("FAIL flush_state got busy=%0h done=%0h v=%0h exp 1/0/0", busy4, done4, rif4.rd_valid); else n_pass++;
    step;
    n_chk++; if (done4 !== 1'b1) $display("FAIL flush_done got %0h exp 1", done4); else n_pass++;
    n_chk++; if (rif4.rd_valid !== 1'b1 || rif4.rd_data !== 8'h01)
      $display("FAIL flush_word got v=%0h d=%h exp 1/01", rif4.rd_valid, rif4.rd_data); else n_pass++;
    n_chk++; if (sig4 !== 16'h0008) $display("FAIL flush_sig got %h exp 0008", sig4); else n_pass++;
    n_chk++; if (overflow4 !== 1'b0) $display("FAIL flush_ovf got %0h exp 0", overflow4); else n_pass++;
    rif4.rd_ready = 1'b1; step; rif4.rd_ready = 1'b0;
    n_chk++; if (rif4.rd_valid !== 1'b0) $display("FAIL flush_empty got %0h exp 0", rif4.rd_valid); else n_pass++;
  endtask

  task automatic test_overflow;
    rif.rd_ready = 1'b0;
    run16(16'h2211);
    run16(16'h4433);
    n_chk++; if (overflow !== 1'b0 || rif.rd_data !== 8'h11)
      $display("FAIL ovf_full got ovf=%0h d=%h exp 0/11", overflow, rif.rd_data); else n_pass++;
    run16(16'h6655);
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_set got %0h exp 1", overflow); else n_pass++;
    n_chk++; if (done !== 1'b1 || rif.rd_data !== 8'h11)
      $display("FAIL ovf_keep got done=%0h d=%h exp 1/11", done, rif.rd_data); else n_pass++;
  endtask

  // FIFO full from the previous test: pop coincides with the first push.
  task automatic test_push_pop_full;
    logic [15:0] bits;
    logic [7:0]  exp_w [4];
    bits = 16'h8877;
    exp_w[0] = 8'h22; exp_w[1] = 8'h33; exp_w[2] = 8'h44; exp_w[3] = 8'h77;
    start = 1'b1; step; start = 1'b0;
    n_chk++; if (overflow !== 1'b0 || busy !== 1'b1)
      $display("FAIL ppf_restart got ovf=%0h busy=%0h exp 0/1", overflow, busy); else n_pass++;
    n_chk++; if (rif.rd_valid !== 1'b1 || rif.rd_data !== 8'h11)
      $display("FAIL ppf_kept got v=%0h d=%h exp 1/11", rif.rd_valid, rif.rd_data); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      sample_in = bits[k];
      rif.rd_ready = (k == 7);
      step;
      if (k == 7) begin
        n_chk++; if (overflow !== 1'b0) $display("FAIL ppf_no_drop got %0h exp 0", overflow); else n_pass++;
        n_chk++; if (rif.rd_data !== 8'h22) $display("FAIL ppf_head got %h exp 22", rif.rd_data); else n_pass++;
      end
    end
    rif.rd_ready = 1'b0;
    n_chk++; if (overflow !== 1'b1) $display("FAIL ppf_late_drop got %0h exp 1", overflow); else n_pass++;
    rif.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (rif.rd_valid !== 1'b1 || rif.rd_data !== exp_w[i])
        $display("FAIL ppf_drain%0d got v=%0h d=%h exp 1/%h", i, rif.rd_valid, rif.rd_data, exp_w[i]); else n_pass++;
      step;
    end
    rif.rd_ready = 1'b0;
    n_chk++; if (rif.rd_valid !== 1'b0) $display("FAIL ppf_empty got %0h exp 0", rif.rd_valid); else n_pass++;
  endtask

  task automatic test_reset_mid;
    run16(16'h00A5);
    start = 1'b1; step; start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample_in = 1'b1; step;
    end
    n_chk++; if (busy !== 1'b1 || sig !== 16'h001F || rif.rd_valid !== 1'b1)
      $display("FAIL mid_pre got busy=%0h sig=%h v=%0h exp 1/001f/1", busy, sig, rif.rd_valid); else n_pass++;
    reset = 1'b1; sample_in = 1'b0; step; reset = 1'b0;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_state got busy=%0h done=%0h exp 0/0", busy, done); else n_pass++;
    n_chk++; if (rif.rd_valid !== 1'b0 || rif.rd_data !== 8'h00)
      $display("FAIL mid_fifo got v=%0h d=%h exp 0/00", rif.rd_valid, rif.rd_data); else n_pass++;
    n_chk++; if (sig !== 16'h0000 || overflow !== 1'b0)
      $display("FAIL mid_sig got sig=%h ovf=%0h exp 0000/0", sig, overflow); else n_pass++;
    start = 1'b1; step; start = 1'b0;
    n_chk++; if (busy !== 1'b1) $display("FAIL mid_restart got %0h exp 1", busy); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      sample_in = 1'b0; step;
    end
    n_chk++; if (done !== 1'b1 || sig !== 16'h0000 || rif.rd_valid !== 1'b1)
      $display("FAIL mid_rerun got done=%0h sig=%h v=%0h exp 1/0000/1", done, sig, rif.rd_valid); else n_pass++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b1; start = 1'b0; sample_in = 1'b0;
    start4 = 1'b0; sample4 = 1'b0;
    rif.rd_ready = 1'b0; rif4.rd_ready = 1'b0;
    test_reset;
    test_zero_run;
    test_pattern;
    test_flush;
    test_overflow;
    test_push_pop_full;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
